// File: rtl/vector_check_pkg.sv
// Shared types for the test-vector checker.
// State encoding for the checker FSM.
package vector_check_pkg;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/vector_checker_if.sv
// Test-vector stream from the stimulus side.
// Carries one result/reference pair per cycle.
interface vector_checker_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_last;
  logic [WIDTH-1:0] dut_out;
  logic [WIDTH-1:0] expected;

  modport master (
    output in_valid,
    output in_last,
    output dut_out,
    output expected
  );

  modport slave (
    input in_valid,
    input in_last,
    input dut_out,
    input expected
  );
endinterface

// File: rtl/vector_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   inc,
  output logic [COUNT_WIDTH-1:0] count
);

  // clear wins over inc; stop at all-ones
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/vector_checker.sv
// Checking end of the test-vector protocol.
// Counts vectors/mismatches, keeps the first failure.
module vector_checker
  import vector_check_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  vector_checker_if.slave        tv,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   mismatch,
  output logic [COUNT_WIDTH-1:0] vector_count,
  output logic [COUNT_WIDTH-1:0] error_count,
  output logic [COUNT_WIDTH-1:0] first_err_index,
  output logic [WIDTH-1:0]       first_err_diff
);

  state_e state_q;
  state_e state_n;

  logic                   accept;
  logic                   miss;
  logic [COUNT_WIDTH-1:0] vec_next;

  // start discards a coincident vector
  assign accept = tv.in_valid && !start
                  && (state_q == RUN);
  assign miss   = accept
                  && (tv.dut_out != tv.expected);

  // index this vector will get, saturated
  assign vec_next = (&vector_count)
                    ? vector_count
                    : vector_count + COUNT_WIDTH'(1);

  sat_counter #(
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_vec_cnt (
    .clock (clock),
    .reset (reset),
    .clear (start),
    .inc   (accept),
    .count (vector_count)
  );

  sat_counter #(
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_err_cnt (
    .clock (clock),
    .reset (reset),
    .clear (start),
    .inc   (miss),
    .count (error_count)
  );

  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // next state: start from anywhere, last ends RUN
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_n = RUN;
      end
      RUN: begin
        if (start) begin
          state_n = RUN;
        end else if (accept && tv.in_last) begin
          state_n = DONE;
        end
      end
      DONE: begin
        if (start) state_n = RUN;
      end
      default: state_n = IDLE;
    endcase
  end

  // registered status flags, pass sees the final vector
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
    end else begin
      busy <= (state_n == RUN);
      done <= (state_n == DONE);
      pass <= (state_n == DONE)
              && (error_count == '0) && !miss;
    end
  end

  // mismatch pulse and first-failure capture
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mismatch        <= 1'b0;
      first_err_index <= '0;
      first_err_diff  <= '0;
    end else if (start) begin
      mismatch        <= 1'b0;
      first_err_index <= '0;
      first_err_diff  <= '0;
    end else begin
      mismatch <= miss;
      if (miss && (first_err_index == '0)) begin
        first_err_index <= vec_next;
        first_err_diff  <= tv.dut_out ^ tv.expected;
      end
    end
  end

endmodule

// File: tb/tb_vector_checker.sv
// Bench for vector_checker.
// Model predictions queued per cycle, popped after the edge.
module tb_vector_checker;

  logic clock;
  logic reset;
  logic start;
  logic start2;

  logic        busy, done, pass, mismatch;
  logic [31:0] vector_count, error_count;
  logic [31:0] first_err_index, first_err_diff;

  logic        busy2, done2, pass2, mismatch2;
  logic [2:0]  vc2, ec2, fi2;
  logic [31:0] fd2;

  int checks;
  int errors;

  vector_checker_if #(.WIDTH(32)) tv ();

  vector_checker #(
    .WIDTH       (32),
    .COUNT_WIDTH (32)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .tv              (tv.slave),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .mismatch        (mismatch),
    .vector_count    (vector_count),
    .error_count     (error_count),
    .first_err_index (first_err_index),
    .first_err_diff  (first_err_diff)
  );

  vector_checker #(
    .WIDTH       (32),
    .COUNT_WIDTH (3)
  ) dut_sat (
    .clock           (clock),
    .reset           (reset),
    .start           (start2),
    .tv              (tv.slave),
    .busy            (busy2),
    .done            (done2),
    .pass            (pass2),
    .mismatch        (mismatch2),
    .vector_count    (vc2),
    .error_count     (ec2),
    .first_err_index (fi2),
    .first_err_diff  (fd2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          busy;
    bit          done;
    bit          pass;
    bit          mis;
    logic [31:0] vc;
    logic [31:0] ec;
    logic [31:0] fi;
    logic [31:0] fd;
  } exp_t;

  exp_t q[$];

  int          m_st;
  logic [31:0] m_vc, m_ec, m_fi, m_fd;
  bit          m_mis;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_st  = 0;
    m_vc  = 0;
    m_ec  = 0;
    m_fi  = 0;
    m_fd  = 0;
    m_mis = 0;
  endtask

  task automatic step(input bit s,
                      input bit s2,
                      input bit v,
                      input bit l,
                      input logic [31:0] d,
                      input logic [31:0] e);
    exp_t x;
    exp_t g;
    @(negedge clock);
    start       = s;
    start2      = s2;
    tv.in_valid = v;
    tv.in_last  = l;
    tv.dut_out  = d;
    tv.expected = e;
    m_mis = 0;
    if (s) begin
      m_vc = 0;
      m_ec = 0;
      m_fi = 0;
      m_fd = 0;
      m_st = 1;
    end else if (m_st == 1 && v) begin
      if (m_vc != 32'hFFFF_FFFF) m_vc = m_vc + 1;
      if (d != e) begin
        if (m_ec != 32'hFFFF_FFFF) m_ec = m_ec + 1;
        m_mis = 1;
        if (m_fi == 0) begin
          m_fi = m_vc;
          m_fd = d ^ e;
        end
      end
      if (l) m_st = 2;
    end
    x.busy = (m_st == 1);
    x.done = (m_st == 2);
    x.pass = (m_st == 2) && (m_ec == 0);
    x.mis  = m_mis;
    x.vc   = m_vc;
    x.ec   = m_ec;
    x.fi   = m_fi;
    x.fd   = m_fd;
    q.push_back(x);
    @(posedge clock);
    #1;
    g = q.pop_front();
    check("busy", 64'(busy), 64'(g.busy));
    check("done", 64'(done), 64'(g.done));
    check("pass", 64'(pass), 64'(g.pass));
    check("mismatch", 64'(mismatch), 64'(g.mis));
    check("vector_count", 64'(vector_count), 64'(g.vc));
    check("error_count", 64'(error_count), 64'(g.ec));
    check("first_err_index", 64'(first_err_index),
          64'(g.fi));
    check("first_err_diff", 64'(first_err_diff),
          64'(g.fd));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_pass"}, 64'(pass), 64'd0);
    check({tag, "_mis"}, 64'(mismatch), 64'd0);
    check({tag, "_vc"}, 64'(vector_count), 64'd0);
    check({tag, "_ec"}, 64'(error_count), 64'd0);
    check({tag, "_fi"}, 64'(first_err_index), 64'd0);
    check({tag, "_fd"}, 64'(first_err_diff), 64'd0);
    check({tag, "_sat_vc"}, 64'(vc2), 64'd0);
    check({tag, "_sat_busy"}, 64'(busy2), 64'd0);
  endtask

  localparam logic [31:0] MA = 32'h0000_FFFF;
  localparam logic [31:0] BD = 32'hFFFF_0001;
  localparam logic [31:0] GD = 32'hFFFF_0000;

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    start       = 1'b0;
    start2      = 1'b0;
    tv.in_valid = 1'b0;
    tv.in_last  = 1'b0;
    tv.dut_out  = '0;
    tv.expected = '0;
    model_clear();

    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    @(negedge clock);
    reset = 1'b1;

    // valid in IDLE is ignored
    step(0, 0, 1, 0, BD, GD);
    step(0, 0, 1, 1, BD, GD);

    // all-match stream of 4
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, MA, MA);
    step(0, 0, 1, 0, MA, MA);
    step(0, 0, 0, 1, BD, GD);
    step(0, 0, 1, 0, MA, MA);
    step(0, 0, 1, 1, MA, MA);
    step(0, 0, 0, 0, 0, 0);

    // valid after DONE is ignored
    step(0, 0, 1, 0, BD, GD);
    step(0, 0, 1, 1, BD, GD);

    // restart from DONE, mismatches at 2 and 3 of 5
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, GD, GD);
    step(0, 0, 1, 0, BD, GD);
    step(0, 0, 1, 0, BD, GD);
    step(0, 0, 1, 0, GD, GD);
    step(0, 0, 1, 1, GD, GD);
    step(0, 0, 0, 0, 0, 0);

    // saturation on the 3-bit instance
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 1, 0, 32'h10 + 32'(i), 32'h0);
    end
    check("sat_vc", 64'(vc2), 64'd7);
    check("sat_ec", 64'(ec2), 64'd7);
    check("sat_fi", 64'(fi2), 64'd1);
    check("sat_fd", 64'(fd2), 64'h10);
    check("sat_busy", 64'(busy2), 64'd1);

    // async reset mid-stream after 3 vectors
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, BD, GD);
    step(0, 0, 1, 0, MA, MA);
    step(0, 0, 1, 0, BD, GD);
    #1;
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    model_clear();
    @(negedge clock);
    reset = 1'b1;
    step(0, 0, 1, 0, BD, GD);
    step(0, 0, 1, 1, BD, GD);

    // final vector mismatches with in_last
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, MA, MA);
    step(0, 0, 1, 0, MA, MA);
    step(0, 0, 1, 1, 32'hA5, 32'h5A);
    step(0, 0, 0, 0, 0, 0);

    // start with in_valid discards that vector
    step(1, 0, 1, 0, BD, GD);
    step(0, 0, 0, 0, 0, 0);

    tv.in_valid = 1'b0;
    start       = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_checker.md
# vector_checker

Synthesizable checking end of the arithmetic-element test-vector protocol. Each cycle the stimulus side presents a DUT result and its expected value; this block compares them, counts vectors and mismatches, and captures the first failing vector. It sits beside any `arithmetic_elements` unit (e.g. `bitwise_or`) for on-FPGA self-test and reports a pass/fail summary when the stream ends.

## Interface
- `WIDTH`, 32, width of the compared result word
- `COUNT_WIDTH`, 32, width of the vector, error and index counters
- `clock`  in  1  system clock, rising-edge active
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; clears all counters and enters RUN
- `in_valid`  in  1  `dut_out`/`expected` valid this cycle (RUN only)
- `in_last`  in  1  qualifies the final vector of the stream; sampled with `in_valid`
- `dut_out`  in  WIDTH  result from the unit under test
- `expected`  in  WIDTH  reference result
- `busy`  out  1  high in RUN
- `done`  out  1  high in DONE, held until `start` or reset
- `pass`  out  1  valid when `done`; high iff `error_count == 0`
- `mismatch`  out  1  one-cycle pulse, registered, for each failing vector
- `vector_count`  out  COUNT_WIDTH  vectors accepted since `start`
- `error_count`  out  COUNT_WIDTH  mismatching vectors since `start`
- `first_err_index`  out  COUNT_WIDTH  1-based index of the first failing vector; 0 if none
- `first_err_diff`  out  WIDTH  `dut_out ^ expected` of the first failing vector

## Operation
- States: IDLE -> RUN on `start`; RUN -> DONE on accepted vector with `in_last`; DONE -> RUN on `start`. There is no other transition out of RUN except reset.
- Reset (asynchronous, `reset` low): state IDLE; all outputs 0, including `pass`.
- `start` in any state: counters, `first_err_*` and `mismatch` cleared; state RUN next cycle. A `start` coinciding with `in_valid` discards that vector.
- Accept: `in_valid` high in RUN. `in_valid` in IDLE/DONE is ignored (no count, no flag).
- Per accepted vector: `vector_count += 1`; if `dut_out != expected` (any bit differs), `error_count += 1`, `mismatch` pulses, and if `first_err_index == 0`, capture `first_err_index = vector_count + 1` (the new count) and `first_err_diff`.
- Counters saturate at all-ones; no wrap. `first_err_index` capture uses the saturated value.
- `in_last` without `in_valid` is ignored. A final vector that also mismatches is counted before DONE; `pass` reflects it.
- `pass` = `done && error_count == 0`, registered.

## Timing
- All outputs registered; 1-cycle latency from accepted vector to updated counters, `mismatch` and `first_err_*`.
- `done` and `pass` rise in the cycle after the `in_last` vector is accepted; `busy` falls in the same cycle.
- Back-to-back `in_valid` every cycle is supported; there is no backpressure.
- Reset mid-RUN: immediate return to IDLE, and partial results are lost.

## Structure
- Shared package `vector_check_pkg`: state enum (IDLE, RUN, DONE) and state width constant.
- One sub-module, `sat_counter` (parameter `COUNT_WIDTH`; ports `clock`, `reset`, `clear`, `inc`, `count`), instantiated for `vector_count` and `error_count`.
- Comparator and first-error capture stay inline.

## Test plan
- All-match stream: `start`, 4 vectors (`0x0000FFFF`/`0x0000FFFF` …), last with `in_last` -> `vector_count=4`, `error_count=0`, `first_err_index=0`, `done=1`, `pass=1`, no `mismatch` pulse.
- Mismatches at vectors 2 and 3 (`dut_out=0xFFFF0001`, `expected=0xFFFF0000`) of 5 -> `error_count=2`, `mismatch` pulses the cycle after 2 and 3, `first_err_index=2`, `first_err_diff=0x00000001`, `pass=0`.
- `in_valid` pulses in IDLE and after DONE -> no counter change. Then `start` in DONE -> counters 0, `busy=1`, and `done=0` next cycle.
- Saturation with `COUNT_WIDTH=3`: 9 mismatching vectors -> `vector_count=7`, `error_count=7`, `first_err_index=1`.
- `reset` low mid-stream after 3 vectors -> all outputs 0 asynchronously and state IDLE; following `in_valid` ignored until `start`.
- Final vector mismatching with `in_last`, and `start` coinciding with `in_valid` -> final vector counted with `pass=0`; the coincident vector is not counted (`vector_count=0`).
